// File: rtl/shift_right_circular_seq_if.sv
// Handshake/data bundle for the multi-step rotate-right unit.
interface shift_right_circular_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] b;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shr;
    logic             busy;
    logic             done;

    modport master (
        output start, b, count,
        input  shr, busy, done
    );

    modport slave (
        input  start, b, count,
        output shr, busy, done
    );
endinterface

// File: rtl/shift_right_circular_seq.sv
// Rotate-right unit: one bit position per step, each step preceded by a
// programmable settle wait; start/busy/done handshake with a held result.
module shift_right_circular_seq #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CNT_W         = 3,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                               clk_i,
    input logic                               reset_i,
    shift_right_circular_seq_if.slave         bus
);
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SetW-1:0] SettleLast =
        SetW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StStep, StDone} state_e;

    state_e           state_q;
    state_e           start_st;
    state_e           after_step_st;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] remain_q;
    logic [SetW-1:0]  settle_q;
    logic [WIDTH-1:0] shr_q;
    logic             busy_q;
    logic             done_q;

    // A zero settle delay skips the SETTLE state entirely.
    always_comb begin
        start_st      = StSettle;
        after_step_st = StSettle;
        if (SETTLE_CYCLES == 0) begin
            start_st      = StStep;
            after_step_st = StStep;
        end
        if (bus.count == '0) begin
            start_st = StDone;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            work_q   <= '0;
            remain_q <= '0;
            settle_q <= '0;
            shr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        work_q   <= bus.b;
                        remain_q <= bus.count;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= start_st;
                    end
                end
                StSettle: begin
                    busy_q <= 1'b1;
                    if (settle_q == SettleLast) begin
                        state_q <= StStep;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StStep: begin
                    busy_q   <= 1'b1;
                    work_q   <= {work_q[0], work_q[WIDTH-1:1]};
                    remain_q <= remain_q - 1'b1;
                    settle_q <= '0;
                    if (remain_q == CNT_W'(1)) begin
                        state_q <= StDone;
                    end else begin
                        state_q <= after_step_st;
                    end
                end
                StDone: begin
                    // Completion edge; a start seen here begins the next op,
                    // busy rises one cycle later so it never overlaps done.
                    shr_q  <= work_q;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        work_q   <= bus.b;
                        remain_q <= bus.count;
                        settle_q <= '0;
                        state_q  <= start_st;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.shr  = shr_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_shift_right_circular_seq.sv
// Directed and randomized checks of the rotate-right unit, with a settle-2
// instance and a settle-0 instance.
module tb_shift_right_circular_seq;
    localparam int unsigned SA = 2;
    localparam int unsigned SB = 0;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    shift_right_circular_seq_if #(.WIDTH(8), .CNT_W(3)) ifa ();
    shift_right_circular_seq_if #(.WIDTH(8), .CNT_W(3)) ifb ();

    shift_right_circular_seq #(.WIDTH(8), .CNT_W(3), .SETTLE_CYCLES(SA)) dut_a (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (ifa)
    );

    shift_right_circular_seq #(.WIDTH(8), .CNT_W(3), .SETTLE_CYCLES(SB)) dut_b (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Rotate right by n expressed as rotate left by (8 - n) mod 8 steps.
    function automatic logic [7:0] ref_ror(input logic [7:0] v, input int n);
        int m;
        int x;
        m = (8 - (n % 8)) % 8;
        x = int'(v);
        for (int i = 0; i < m; i++) begin
            x = ((x << 1) | (x >> 7)) & 8'hFF;
        end
        return x[7:0];
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [7:0] bv,
                         input logic [2:0] n);
        if (sel) begin
            ifb.start = st; ifb.b = bv; ifb.count = n;
        end else begin
            ifa.start = st; ifa.b = bv; ifa.count = n;
        end
    endtask

    function automatic logic [7:0] rd_shr(input bit sel);
        return sel ? ifb.shr : ifa.shr;
    endfunction

    function automatic logic rd_busy(input bit sel);
        return sel ? ifb.busy : ifa.busy;
    endfunction

    function automatic logic rd_done(input bit sel);
        return sel ? ifb.done : ifa.done;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, then watch latency, result, held shr and busy.
    task automatic run_op(input bit sel, input logic [7:0] bv, input logic [2:0] n,
                          input string tag);
        int         lat_exp;
        int         k;
        bit         seen;
        bit         held_ok;
        bit         busy_ok;
        logic [7:0] old;
        lat_exp = int'(n) * (int'(sel ? SB : SA) + 1) + 1;
        old     = rd_shr(sel);
        drive(sel, 1'b1, bv, n);
        tick();
        drive(sel, 1'b0, 8'h00, 3'd0);
        k = 0; seen = 0; held_ok = 1; busy_ok = 1;
        while (!seen && k < 300) begin
            tick();
            k++;
            if (rd_done(sel)) begin
                seen = 1;
            end else begin
                if (rd_shr(sel) !== old) held_ok = 0;
                if (rd_busy(sel) !== 1'b1) busy_ok = 0;
            end
        end
        check({tag, " latency"}, k, lat_exp);
        check({tag, " shr"}, {24'd0, rd_shr(sel)}, {24'd0, ref_ror(bv, int'(n))});
        check({tag, " busy at done"}, {31'd0, rd_busy(sel)}, 32'd0);
        check({tag, " shr held"}, {31'd0, held_ok}, 32'd1);
        check({tag, " busy during"}, {31'd0, busy_ok}, 32'd1);
        tick();
        check({tag, " done one cycle"}, {31'd0, rd_done(sel)}, 32'd0);
    endtask

    initial begin
        int first_done;
        int ndone;
        int d1;
        int d2;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 1'b0, 8'h00, 3'd0);
        drive(1, 1'b0, 8'h00, 3'd0);
        tick();
        tick();
        check("reset shr", {24'd0, ifa.shr}, 32'd0);
        check("reset busy", {31'd0, ifa.busy}, 32'd0);
        check("reset done", {31'd0, ifa.done}, 32'd0);
        rst = 1'b0;
        tick();

        run_op(0, 8'h81, 3'd1, "t1 81r1");
        run_op(0, 8'hB4, 3'd3, "t2 B4r3");
        run_op(0, 8'h01, 3'd7, "t3 01r7");
        run_op(0, 8'h5A, 3'd0, "t3 5Ar0");

        // Start while busy must be ignored.
        drive(0, 1'b1, 8'h81, 3'd1);
        tick();
        drive(0, 1'b0, 8'h00, 3'd0);
        tick();
        drive(0, 1'b1, 8'hFF, 3'd5);
        tick();
        drive(0, 1'b0, 8'h00, 3'd0);
        first_done = -1; ndone = 0;
        for (int k = 3; k <= 20; k++) begin
            tick();
            if (ifa.done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
        end
        check("t4 done cycle", first_done, 4);
        check("t4 done count", ndone, 1);
        check("t4 shr", {24'd0, ifa.shr}, 32'h0000_00C0);

        // Reset mid-run aborts the operation.
        drive(0, 1'b1, 8'hB4, 3'd3);
        tick();
        drive(0, 1'b0, 8'h00, 3'd0);
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 shr after reset", {24'd0, ifa.shr}, 32'd0);
        check("t5 busy after reset", {31'd0, ifa.busy}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ifa.done) ndone++;
        end
        check("t5 no done after abort", ndone, 0);
        run_op(0, 8'h81, 3'd1, "t5 81r1");

        // Start held through DONE: back-to-back operations.
        drive(0, 1'b1, 8'h03, 3'd1);
        tick();
        d1 = -1; d2 = -1; ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) drive(0, 1'b0, 8'h00, 3'd0);
            if (ifa.done) begin
                ndone++;
                check("t6 shr at done", {24'd0, ifa.shr}, 32'h0000_0081);
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        check("t6 first done", d1, 4);
        check("t6 second done", d2, 8);
        check("t6 done count", ndone, 2);

        run_op(1, 8'hB4, 3'd3, "s0 B4r3");
        run_op(1, 8'h5A, 3'd0, "s0 5Ar0");

        for (int i = 0; i < 24; i++) begin
            logic [7:0] rb;
            logic [2:0] rn;
            rb = 8'($urandom_range(0, 255));
            rn = 3'($urandom_range(0, 7));
            run_op(i[0], rb, rn, i[0] ? "rand s0" : "rand s2");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
